// File: rtl/piccolo_round_ctrl.sv
// rtl/piccolo_round_ctrl.sv - Iterative round sequencer for the Piccolo-80 datapath
module piccolo_round_ctrl #(
  parameter int ROUNDS = 25,
  parameter int RK_W   = 800
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_valid,
  input  logic [63:0]     wk,
  input  logic [RK_W-1:0] rk,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     in_data,
  output logic [63:0]     rf_in,
  output logic [31:0]     rf_rk,
  output logic            rf_last,
  input  logic [63:0]     rf_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [63:0]     out_data,
  output logic            busy,
  output logic            abort_err
);
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t          fsm_q, fsm_d;
  logic [63:0]   state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic          abort_q, abort_d;
  logic          ready_en_q, ready_en_d;
  logic [31:0]   rk_pair [ROUNDS];

  for (genvar i = 0; i < ROUNDS; i++) begin : g_rk
    assign rk_pair[i] = rk[RK_W-1-32*i -: 32];
  end

  assign rf_in     = state_q;
  assign rf_rk     = rk_pair[round_q];
  assign out_data  = state_q;
  assign busy      = (fsm_q != IDLE);
  assign abort_err = abort_q;

  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    round_d    = round_q;
    abort_d    = 1'b0;
    ready_en_d = 1'b1;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    rf_last    = 1'b0;
    case (fsm_q)
      IDLE: begin
        // ready_en_q keeps in_ready low until the first edge after reset release
        in_ready = ready_en_q & key_valid;
        if (in_valid && in_ready) begin
          state_d = {in_data[63:48] ^ wk[63:48], in_data[47:32],
                     in_data[31:16] ^ wk[47:32], in_data[15:0]};
          round_d = '0;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        rf_last = (round_q == LAST_ROUND);
        if (!key_valid) begin
          abort_d = 1'b1;
          round_d = '0;
          fsm_d   = IDLE;
        end else if (rf_last) begin
          state_d = {rf_out[63:48] ^ wk[31:16], rf_out[47:32],
                     rf_out[31:16] ^ wk[15:0], rf_out[15:0]};
          round_d = '0;
          fsm_d   = DONE;
        end else begin
          state_d = rf_out;
          round_d = round_q + RW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= IDLE;
      state_q    <= '0;
      round_q    <= '0;
      abort_q    <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      round_q    <= round_d;
      abort_q    <= abort_d;
      ready_en_q <= ready_en_d;
    end
  end
endmodule
